// File: rtl/acc_burst_stager.sv
// acc_burst_stager: elastic FIFO between the accelerator result stream and the
// DMA ACC input. Buffers results, requests a burst once BURST words are held
// (or on flush), and after grant streams the burst as gap-free valid beats.
module acc_burst_stager #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,   // power of two, >= BURST
  parameter int BURST      = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          acc_valid_i,
  input  logic [DATA_WIDTH-1:0]         acc_data_i,
  output logic                          acc_ready_o,
  input  logic                          flush_i,
  output logic                          dma_burst_req_o,
  output logic [$clog2(BURST+1)-1:0]    dma_burst_len_o,
  input  logic                          dma_burst_gnt_i,
  output logic                          acc_data_valid_o,
  output logic [DATA_WIDTH-1:0]         acc_data_o,
  output logic                          burst_done_o,
  output logic [$clog2(DEPTH+1)-1:0]    level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(BURST + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [LW-1:0] BURST_L = LW'(BURST);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         beat_q, beat_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  push, pop, pend_eff;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Ready comes only from the registered count, so a same-cycle pop never
  // reopens a full FIFO.
  assign acc_ready_o      = (count_q < DEPTH_C);
  assign push             = acc_valid_i && acc_ready_o;
  assign pend_eff         = flush_pend_q || flush_i;

  assign dma_burst_req_o  = (state_q == ST_REQ);
  assign dma_burst_len_o  = len_q;
  assign acc_data_valid_o = valid_q;
  assign acc_data_o       = data_q;
  assign burst_done_o     = done_q;
  assign level_o          = count_q;

  // Next-state and burst control; every pop happens in SEND, one per cycle.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_d       = beat_q;
    flush_pend_d = pend_eff;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (count_q >= BURST_C) begin
          // Full burst wins over a pending flush; a full burst that empties
          // the FIFO satisfies the flush too.
          len_d   = BURST_L;
          beat_d  = BURST_L;
          state_d = ST_REQ;
          if (count_q == BURST_C) flush_pend_d = 1'b0;
        end else if (pend_eff && (count_q != '0)) begin
          len_d        = count_q[LW-1:0];
          beat_d       = count_q[LW-1:0];
          flush_pend_d = 1'b0;
          state_d      = ST_REQ;
        end else if (count_q == '0) begin
          flush_pend_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (dma_burst_gnt_i) state_d = ST_SEND;
      end
      ST_SEND: begin
        pop     = 1'b1;
        valid_d = 1'b1;
        beat_d  = beat_q - ONE_L;
        if (beat_q == ONE_L) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy: push and pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Control and pointer registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage array, written on accepted pushes.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr_q] <= acc_data_i;
  end

  // Registered read; data holds its last value between bursts.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)  data_q <= '0;
    else if (pop)  data_q <= mem[rd_ptr_q];
  end

endmodule

// File: tb/tb_acc_burst_stager.sv
// Bench for acc_burst_stager: directed scenarios with a data scoreboard.
module tb_acc_burst_stager;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_valid;
  logic [31:0] acc_data;
  logic        acc_ready;
  logic        flush;
  logic        req;
  logic [2:0]  len;
  logic        gnt;
  logic        dvalid;
  logic [31:0] dout;
  logic        done;
  logic [3:0]  level;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  acc_burst_stager #(.DATA_WIDTH(32), .DEPTH(8), .BURST(4)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .acc_valid_i     (acc_valid),
    .acc_data_i      (acc_data),
    .acc_ready_o     (acc_ready),
    .flush_i         (flush),
    .dma_burst_req_o (req),
    .dma_burst_len_o (len),
    .dma_burst_gnt_i (gnt),
    .acc_data_valid_o(dvalid),
    .acc_data_o      (dout),
    .burst_done_o    (done),
    .level_o         (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat scoreboard: every valid beat must match the oldest accepted word.
  always @(negedge clk) begin
    if (!rst && dvalid) begin
      if (exp_q.size() == 0) check("beat_unexpected", dout, 32'hDEAD_BEEF);
      else check("beat_data", dout, exp_q.pop_front());
    end
  end

  task automatic push_word(input logic [31:0] d, input logic exp_acc);
    acc_valid = 1'b1;
    acc_data  = d;
    check("push_ready", {31'd0, acc_ready}, {31'd0, exp_acc});
    if (exp_acc) exp_q.push_back(d);
    tick();
    acc_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("req_timeout", {31'd0, req}, 32'd1);
  endtask

  // Wait for a request, grant it, and check the beat train; optionally push
  // words while the burst is being sent.
  task automatic do_burst(input int exp_len, input int npush, input logic [31:0] base,
                          input int exp_level);
    wait_req();
    check("req_len", {29'd0, len}, exp_len);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("no_beat_at_grant", {31'd0, dvalid}, 32'd0);
    for (int i = 1; i <= exp_len; i++) begin
      if (i <= npush) begin
        acc_valid = 1'b1;
        acc_data  = base + i;
        exp_q.push_back(base + i);
      end else begin
        acc_valid = 1'b0;
      end
      tick();
      check("beat_valid", {31'd0, dvalid}, 32'd1);
      check("beat_done", {31'd0, done}, (i == exp_len) ? 32'd1 : 32'd0);
    end
    acc_valid = 1'b0;
    check("level_after_burst", {28'd0, level}, exp_level);
    tick();
    check("valid_after_burst", {31'd0, dvalid}, 32'd0);
    check("done_after_burst", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; acc_valid = 1'b0; acc_data = '0; flush = 1'b0; gnt = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ready", {31'd0, acc_ready}, 32'd1);
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_len", {29'd0, len}, 32'd0);
    check("rst_valid", {31'd0, dvalid}, 32'd0);
    check("rst_data", dout, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_level", {28'd0, level}, 32'd0);

    // 1: one full burst
    for (int i = 1; i <= 4; i++) push_word(32'h11 * i, 1'b1);
    do_burst(4, 0, 0, 0);

    // 2: fill to full, refused 9th word, two bursts
    for (int i = 0; i < 8; i++) push_word(32'hA0 + i, 1'b1);
    check("full_ready", {31'd0, acc_ready}, 32'd0);
    check("full_level", {28'd0, level}, 32'd8);
    push_word(32'h99, 1'b0);
    check("full_level_9th", {28'd0, level}, 32'd8);
    do_burst(4, 0, 0, 4);
    check("ready_after_drain", {31'd0, acc_ready}, 32'd1);
    do_burst(4, 0, 0, 0);

    // 3: partial burst via flush
    for (int i = 0; i < 3; i++) push_word(32'hC0 + i, 1'b1);
    tick();
    check("no_req_before_flush", {31'd0, req}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_burst(3, 0, 0, 0);

    // 4: pushes during SEND stay buffered
    for (int i = 0; i < 4; i++) push_word(32'hD0 + i, 1'b1);
    do_burst(4, 2, 32'hE0, 2);
    for (int i = 0; i < 5; i++) begin
      check("no_req_with_2", {31'd0, req}, 32'd0);
      tick();
    end
    push_word(32'hF1, 1'b1);
    push_word(32'hF2, 1'b1);
    do_burst(4, 0, 0, 0);

    // 5: reset on the second beat
    for (int i = 0; i < 4; i++) push_word(32'h50 + i, 1'b1);
    wait_req();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    tick();
    check("rst5_beat1_valid", {31'd0, dvalid}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst5_valid", {31'd0, dvalid}, 32'd0);
    check("rst5_req", {31'd0, req}, 32'd0);
    check("rst5_level", {28'd0, level}, 32'd0);
    check("rst5_ready", {31'd0, acc_ready}, 32'd1);
    rst = 1'b0;
    exp_q.delete();
    tick();

    // 6: grant held high from the start
    gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gnt_early_valid", {31'd0, dvalid}, 32'd0);
      check("gnt_early_req", {31'd0, req}, 32'd0);
    end
    for (int i = 0; i < 4; i++) push_word(32'h60 + i, 1'b1);
    tick();
    check("gnt6_req", {31'd0, req}, 32'd1);
    check("gnt6_len", {29'd0, len}, 32'd4);
    tick();
    check("gnt6_send_no_beat", {31'd0, dvalid}, 32'd0);
    check("gnt6_req_dropped", {31'd0, req}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("gnt6_beat_valid", {31'd0, dvalid}, 32'd1);
      check("gnt6_beat_done", {31'd0, done}, (i == 4) ? 32'd1 : 32'd0);
    end
    tick();
    check("gnt6_valid_end", {31'd0, dvalid}, 32'd0);
    check("gnt6_level", {28'd0, level}, 32'd0);
    gnt = 1'b0;
    tick();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
